// File: rtl/uart_frame_sender.sv
// Serialises one latched cube frame as back-to-back 8N1 UART bytes, byte 0 first, LSB first.
// frame_start is honoured only while idle; the frame is captured whole on acceptance.
module uart_frame_sender #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int FRAME_BYTES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8*FRAME_BYTES-1:0] frame_cube_flat,
  input  logic                     frame_start,
  output logic                     tx,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_BYTES - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_frame_sender: CLK_FREQ/BAUD must be at least 2");
    end
    if (FRAME_BYTES < 1) begin : g_bad_frame
      $error("uart_frame_sender: FRAME_BYTES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         baud_q, baud_d;
  logic [2:0]               bit_q, bit_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     tx_q, tx_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     load;
  logic                     wrap;
  logic [IDX_W+2:0]         sel_d;
  logic [8*FRAME_BYTES-1:0] buf_q;

  assign wrap  = (baud_q == BAUD_LAST);
  assign sel_d = {idx_d, bit_d};

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          load    = 1'b1;
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (wrap) begin
          baud_d = '0;
          if (idx_q < IDX_LAST) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered, so it is derived from the state being entered.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = buf_q[sel_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) buf_q <= frame_cube_flat;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Directed bench for uart_frame_sender at 16 clocks per bit and 4-byte frames.
module tb_uart_frame_sender;

  logic        clk;
  logic        rst_n;
  logic [31:0] frame_cube_flat;
  logic        frame_start;
  logic        tx;
  logic        busy;
  logic        frame_done;

  int vectors    = 0;
  int miscompares = 0;

  uart_frame_sender #(
    .CLK_FREQ   (16),
    .BAUD       (1),
    .FRAME_BYTES(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_cube_flat(frame_cube_flat),
    .frame_start    (frame_start),
    .tx             (tx),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"}, {31'd0, tx}, 32'd1);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " frame_done"}, {31'd0, frame_done}, 32'd0);
  endtask

  // Line level c cycles after the accepting edge: 10 bits of 16 cycles per byte.
  function automatic logic exp_tx(input logic [31:0] d, input int c);
    int j, byt, b;
    j   = c / 16;
    byt = j / 10;
    b   = j % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[8*byt + b - 1];
  endfunction

  task automatic start_frame(input logic [31:0] d);
    @(negedge clk);
    frame_cube_flat = d;
    frame_start     = 1'b1;
    @(negedge clk);
  endtask

  // Entered one half-cycle after the accepting edge (c = 0).
  task automatic watch(input logic [31:0] d, input int pa, input int pb, input bit zero_data,
                       input bit chain, input logic [31:0] nxt, input int abort_at);
    for (int c = 0; c <= 640; c++) begin
      if (c == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_idle($sformatf("abort c=%0d", c));
        return;
      end
      frame_start = (c == pa) || (c == pb);
      if (frame_start) frame_cube_flat = 32'hDEAD_BEEF;
      if (zero_data && c == 0) frame_cube_flat = 32'h0;
      if (c < 640) begin
        check($sformatf("tx c=%0d", c), {31'd0, tx}, {31'd0, exp_tx(d, c)});
        check($sformatf("busy c=%0d", c), {31'd0, busy}, 32'd1);
        check($sformatf("frame_done c=%0d", c), {31'd0, frame_done}, 32'd0);
      end else begin
        check("end tx", {31'd0, tx}, 32'd1);
        check("end busy", {31'd0, busy}, 32'd0);
        check("end frame_done", {31'd0, frame_done}, 32'd1);
      end
      if (c == 640 && chain) begin
        frame_cube_flat = nxt;
        frame_start     = 1'b1;
      end
      @(negedge clk);
    end
    if (!chain) begin
      for (int k = 0; k < 20; k++) begin
        check_idle($sformatf("post-frame idle k=%0d", k));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst_n           = 1'b1;
    frame_start     = 1'b0;
    frame_cube_flat = 32'h0;

    // Asynchronous reset asserted between clock edges.
    #2 rst_n = 1'b0;
    #1 check_idle("reset async");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle($sformatf("reset held k=%0d", k));
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_idle($sformatf("idle k=%0d", k));
    end

    // Single frame: FF, 01, 3C, A5 on the line.
    start_frame(32'hA5_3C_01_FF);
    watch(32'hA5_3C_01_FF, -1, -1, 1'b0, 1'b0, 32'h0, -1);

    // Input changes right after acceptance; latched bytes still go out.
    start_frame(32'h1234_5678);
    watch(32'h1234_5678, -1, -1, 1'b1, 1'b0, 32'h0, -1);

    // Starts at cycles 50 and 300 of a frame are ignored.
    start_frame(32'h0F0F_55AA);
    watch(32'h0F0F_55AA, 50, 300, 1'b0, 1'b0, 32'h0, -1);

    // Back-to-back: second start coincides with the first frame_done.
    start_frame(32'h80C3_E701);
    watch(32'h80C3_E701, -1, -1, 1'b0, 1'b1, 32'h7E81_FF00, -1);
    watch(32'h7E81_FF00, -1, -1, 1'b0, 1'b0, 32'h0, -1);

    // Reset in the middle of byte 2 abandons the frame without frame_done.
    start_frame(32'hC0FF_EE11);
    watch(32'hC0FF_EE11, -1, -1, 1'b0, 1'b0, 32'h0, 360);
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("abort held");
    rst_n = 1'b1;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      check_idle($sformatf("after abort k=%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
